conv_encoder: RTL and testbench

//  Streaming rate-1/2 convolutional encoder: one info bit in, one 2-bit symbol out.

---
 rtl/conv_encoder_if.sv | 32 +++
 rtl/conv_encoder.sv | 117 +++++++++++
 tb/tb_conv_encoder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_encoder_if.sv
// conv_encoder_if
//  Bundles the info-bit input stream and the coded-symbol output stream of the
//  convolutional encoder.
//  master : the side that feeds info bits and sinks symbols (e.g. a framer or bench)
//  slave  : the encoder itself
//  Signals:
//   in_valid/in_ready/in_bit/in_last   info-bit stream (valid/ready)
//   out_valid/out_ready/out_sym        coded-symbol stream {c0,c1}
//   out_tail/out_last                  symbol came from a tail bit / ends the frame
//   busy                               frame in progress
interface conv_encoder_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_sym;
    logic       out_tail;
    logic       out_last;
    logic       busy;

    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_sym, out_tail, out_last, busy
    );

    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_sym, out_tail, out_last, busy
    );
endinterface

// File: rtl/conv_encoder.sv
// conv_encoder
//  Streaming rate-1/2 convolutional encoder, one info bit in, one 2-bit symbol out.
//  Shares the trellis convention of the Viterbi decoder: reg = {state, b} with the
//  newest bit in bit 0; next state = reg[M-1:0]. With TERMINATE=1 each frame is
//  followed by M zero tail bits so the trellis ends in state 0.
//  Ports:
//   clk   clock
//   rst   synchronous reset, active-high
//   bus   conv_encoder_if.slave (info-bit input stream, symbol output stream, busy)
//
//  state | meaning
//  RUN   | accepting info bits, one symbol per accepted bit
//  TAIL  | input blocked, emitting zero-input tail symbols until tail_cnt reaches 1
module conv_encoder #(
    parameter int K         = 5,
    parameter int M         = K - 1,
    parameter int G0_OCT    = 'o23,
    parameter int G1_OCT    = 'o35,
    parameter bit TERMINATE = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    conv_encoder_if.slave bus
);
    localparam int TW = $clog2(M + 1);
    localparam logic [K-1:0] G0_MASK = K'(G0_OCT);
    localparam logic [K-1:0] G1_MASK = K'(G1_OCT);

    typedef enum logic {RUN = 1'b0, TAIL = 1'b1} fsm_t;

    fsm_t          fsm;
    logic [M-1:0]  enc_state;
    logic [TW-1:0] tail_cnt;
    logic          out_valid_q;
    logic [1:0]    out_sym_q;
    logic          out_tail_q;
    logic          out_last_q;

    logic          slot_free;
    logic          accept;
    logic          tail_issue;
    logic          enc_bit;
    logic [K-1:0]  shift_reg;
    logic [M-1:0]  next_state;
    logic [1:0]    sym_next;
    logic          tail_final;

    // The output register can take a new symbol when it is empty or being drained.
    assign slot_free  = !out_valid_q || bus.out_ready;
    assign bus.in_ready = (fsm == RUN) && slot_free;
    assign accept     = bus.in_valid && bus.in_ready;
    assign tail_issue = (fsm == TAIL) && slot_free;

    // Tail slots encode a zero input bit.
    assign enc_bit    = accept ? bus.in_bit : 1'b0;
    assign shift_reg  = {enc_state, enc_bit};
    assign next_state = shift_reg[M-1:0];
    assign sym_next   = {^(shift_reg & G0_MASK), ^(shift_reg & G1_MASK)};
    assign tail_final = (tail_cnt == TW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= RUN;
            enc_state   <= '0;
            tail_cnt    <= '0;
            out_valid_q <= 1'b0;
            out_sym_q   <= 2'b00;
            out_tail_q  <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_sym_q   <= sym_next;
            out_tail_q  <= 1'b0;
            if (bus.in_last && TERMINATE) begin
                enc_state  <= next_state;
                tail_cnt   <= TW'(M);
                fsm        <= TAIL;
                out_last_q <= 1'b0;
            end else if (bus.in_last) begin
                // Truncated frame: next frame restarts the trellis from state 0.
                enc_state  <= '0;
                out_last_q <= 1'b1;
            end else begin
                enc_state  <= next_state;
                out_last_q <= 1'b0;
            end
        end else if (tail_issue) begin
            out_valid_q <= 1'b1;
            out_sym_q   <= sym_next;
            out_tail_q  <= 1'b1;
            out_last_q  <= tail_final;
            tail_cnt    <= tail_cnt - TW'(1);
            if (tail_final) begin
                // Already zero after M shifts of 0; forced for robustness.
                enc_state <= '0;
                fsm       <= RUN;
            end else begin
                enc_state <= next_state;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sym   = out_sym_q;
    assign bus.out_tail  = out_tail_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (enc_state != '0) || (fsm == TAIL) || out_valid_q;

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid_q && !bus.out_ready) |=>
            (out_valid_q && $stable(out_sym_q) && $stable(out_tail_q) && $stable(out_last_q)));

    a_term_state0: assert property (@(posedge clk) disable iff (rst)
        (TERMINATE && out_valid_q && out_last_q) |-> (enc_state == '0));
endmodule

// File: tb/tb_conv_encoder.sv
module tb_conv_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    conv_encoder_if bus_a();
    conv_encoder_if bus_b();

    conv_encoder #(.K(5), .G0_OCT('o23), .G1_OCT('o35), .TERMINATE(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    conv_encoder #(.K(5), .G0_OCT('o23), .G1_OCT('o35), .TERMINATE(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    // Golden encoder: taps o23 -> reg bits 4,1,0 ; o35 -> reg bits 4,3,2,0.
    function automatic logic [1:0] expected_bits(input logic [3:0] pred, input logic b);
        logic [4:0] r;
        r = {pred, b};
        return {r[4] ^ r[1] ^ r[0], r[4] ^ r[3] ^ r[2] ^ r[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle_a(input string tag);
        chk1({tag, "_valid"}, bus_a.out_valid, 1'b0);
        chk4({tag, "_sym"},   {2'b00, bus_a.out_sym}, 4'h0);
        chk1({tag, "_tail"},  bus_a.out_tail, 1'b0);
        chk1({tag, "_last"},  bus_a.out_last, 1'b0);
        chk1({tag, "_busy"},  bus_a.busy, 1'b0);
    endtask

    // Impulse frame on the terminated encoder: 11,10,01,01,11.
    task automatic impulse_a(input string tag);
        logic [9:0] exp_syms;
        exp_syms = 10'b11_10_01_01_11;
        bus_a.out_ready = 1'b1;
        bus_a.in_valid  = 1'b1;
        bus_a.in_bit    = 1'b1;
        bus_a.in_last   = 1'b1;
        #1;
        chk1({tag, "_in_ready0"}, bus_a.in_ready, 1'b1);
        tick();
        bus_a.in_valid = 1'b0;
        bus_a.in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk1({tag, "_valid"}, bus_a.out_valid, 1'b1);
            chk4({tag, "_sym"},   {2'b00, bus_a.out_sym}, {2'b00, exp_syms[9 - 2*i -: 2]});
            chk1({tag, "_tail"},  bus_a.out_tail, i > 0);
            chk1({tag, "_last"},  bus_a.out_last, i == 4);
            chk1({tag, "_busy"},  bus_a.busy, 1'b1);
            chk1({tag, "_in_ready"}, bus_a.in_ready, i == 4);
            tick();
        end
        chk1({tag, "_valid_end"}, bus_a.out_valid, 1'b0);
        chk1({tag, "_busy_end"},  bus_a.busy, 1'b0);
    endtask

    // One frame of nbits through the terminated encoder against a queue-based model.
    // rand_mode=0: fixed bit pattern, sink stalls for three cycles mid-frame.
    task automatic stream_a(input int nbits, input bit rand_mode, input string tag);
        logic [3:0] st;
        logic [3:0] q[$];
        logic [3:0] exp_t;
        logic [3:0] held;
        logic [7:0] pat;
        logic       mv;
        logic       stall_prev;
        logic       slot;
        logic       exp_rdy;
        logic       acc;
        logic       issue;
        int         sent;
        int         tails;
        int         cyc;
        st = 4'h0; mv = 1'b0; stall_prev = 1'b0; held = 4'h0;
        pat = 8'b1011_0011;
        sent = 0; tails = 0; cyc = 0;
        while ((sent < nbits || q.size() > 0) && cyc < 20000) begin
            if (rand_mode) begin
                bus_a.in_valid  = (sent < nbits) && ($urandom_range(0, 9) < 7);
                bus_a.out_ready = ($urandom_range(0, 9) < 7);
                bus_a.in_bit    = 1'($urandom_range(0, 1));
            end else begin
                bus_a.in_valid  = (sent < nbits);
                bus_a.out_ready = !(cyc >= 3 && cyc <= 5);
                bus_a.in_bit    = pat[3'(sent % 8)];
            end
            bus_a.in_last = (sent == nbits - 1);
            #1;
            chk1({tag, "_valid"}, bus_a.out_valid, mv);
            if (stall_prev)
                chk4({tag, "_hold"}, {bus_a.out_sym, bus_a.out_tail, bus_a.out_last}, held);
            slot    = !mv || bus_a.out_ready;
            exp_rdy = (tails == 0) && slot;
            chk1({tag, "_in_ready"}, bus_a.in_ready, exp_rdy);
            if (mv && bus_a.out_ready) begin
                exp_t = q.pop_front();
                chk4({tag, "_sym"}, {bus_a.out_sym, bus_a.out_tail, bus_a.out_last}, exp_t);
            end
            stall_prev = mv && !bus_a.out_ready;
            held  = {bus_a.out_sym, bus_a.out_tail, bus_a.out_last};
            acc   = bus_a.in_valid && exp_rdy;
            issue = (tails > 0) && slot;
            if (acc) begin
                q.push_back({expected_bits(st, bus_a.in_bit), 2'b00});
                st = {st[2:0], bus_a.in_bit};
                if (bus_a.in_last) begin
                    for (int t = 0; t < 4; t++) begin
                        q.push_back({expected_bits(st, 1'b0), 1'b1, t == 3});
                        st = {st[2:0], 1'b0};
                    end
                    tails = 4;
                end
                sent++;
            end else if (issue) begin
                tails--;
            end
            mv = acc || issue || (mv && !bus_a.out_ready);
            tick();
            cyc++;
        end
        if (cyc >= 20000) begin
            n_vec++;
            n_err++;
            $error("FAIL %s_timeout: observed %0d pending expected 0", tag, q.size());
        end
        bus_a.in_valid = 1'b0;
        bus_a.in_last  = 1'b0;
        #1;
        chk1({tag, "_busy_end"}, bus_a.busy, 1'b0);
    endtask

    initial begin
        bus_a.in_valid = 1'b0; bus_a.in_bit = 1'b0; bus_a.in_last = 1'b0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_bit = 1'b0; bus_b.in_last = 1'b0; bus_b.out_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk_idle_a("rst");
        chk1("rst_b_busy", bus_b.busy, 1'b0);
        rst = 1'b0;
        #1;
        chk1("rst_in_ready", bus_a.in_ready, 1'b1);

        // Impulse response with tail
        impulse_a("imp1");

        // All-zero 8-bit frame -> 12 zero symbols, last on the 12th
        bus_a.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus_a.in_valid = (i < 8);
            bus_a.in_bit   = 1'b0;
            bus_a.in_last  = (i == 7);
            tick();
            chk1("zero_valid", bus_a.out_valid, 1'b1);
            chk4("zero_sym",   {2'b00, bus_a.out_sym}, 4'h0);
            chk1("zero_tail",  bus_a.out_tail, i >= 8);
            chk1("zero_last",  bus_a.out_last, i == 11);
        end
        bus_a.in_valid = 1'b0;
        bus_a.in_last  = 1'b0;
        tick();
        chk1("zero_valid_end", bus_a.out_valid, 1'b0);
        chk1("zero_busy_end",  bus_a.busy, 1'b0);

        // Backpressure mid-frame
        stream_a(8, 1'b0, "bp");

        // Truncated frames on the TERMINATE=0 encoder: 1,1 -> 11,01 then restart at state 0
        bus_b.in_valid = 1'b1; bus_b.in_bit = 1'b1; bus_b.in_last = 1'b0;
        tick();
        chk4("trunc_sym0",  {2'b00, bus_b.out_sym}, 4'h3);
        chk1("trunc_last0", bus_b.out_last, 1'b0);
        bus_b.in_last = 1'b1;
        tick();
        chk4("trunc_sym1",  {2'b00, bus_b.out_sym}, 4'h1);
        chk1("trunc_last1", bus_b.out_last, 1'b1);
        chk1("trunc_tail1", bus_b.out_tail, 1'b0);
        bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
        tick();
        chk1("trunc_valid_idle", bus_b.out_valid, 1'b0);
        chk1("trunc_busy_idle",  bus_b.busy, 1'b0);
        bus_b.in_valid = 1'b1; bus_b.in_bit = 1'b1; bus_b.in_last = 1'b1;
        tick();
        chk4("trunc_f2_sym",  {2'b00, bus_b.out_sym}, 4'h3);
        chk1("trunc_f2_last", bus_b.out_last, 1'b1);
        bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
        tick();
        chk1("trunc_f2_valid_end", bus_b.out_valid, 1'b0);

        // Reset during the second tail symbol
        bus_a.out_ready = 1'b1;
        bus_a.in_valid = 1'b1; bus_a.in_bit = 1'b1; bus_a.in_last = 1'b1;
        tick();
        bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
        tick();
        tick();
        chk4("mid_tail_sym", {2'b00, bus_a.out_sym}, 4'h1);
        chk1("mid_tail_flag", bus_a.out_tail, 1'b1);
        rst = 1'b1;
        tick();
        chk_idle_a("mid_rst");
        rst = 1'b0;
        #1;
        chk1("mid_rst_in_ready", bus_a.in_ready, 1'b1);
        impulse_a("imp2");

        // Long random frame with random valid/ready
        stream_a(1000, 1'b1, "rnd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
